// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller: RUN/SET mode sequencing, counter strobes,
// count-enable gating, digit blink mask and inactivity timeout back to RUN.
module watch_set_ctrl #(
   parameter int unsigned TIMEOUT_S = 10
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       KEY_MODE,
   input  logic       KEY_INC,
   input  logic       KEY_CLR,
   input  logic       TICK_1HZ,
   input  logic       TICK_2HZ,
   output logic       RUN_EN,
   output logic       INC_SEC,
   output logic       INC_MIN,
   output logic       INC_HOUR,
   output logic       CLR_SEC,
   output logic [1:0] MODE,
   output logic [5:0] BLINK_N
);

   localparam int unsigned TW = 8;
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] SET_HOUR = 2'd1;
   localparam logic [1:0] SET_MIN  = 2'd2;
   localparam logic [1:0] SET_SEC  = 2'd3;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          phase, phase_nxt;
   logic [1:0]    mode_nxt;
   logic          run_en_nxt, inc_sec_nxt, inc_min_nxt, inc_hour_nxt, clr_sec_nxt;
   logic [5:0]    blink_nxt;
   logic          timeout, key_any, mode_chg;

   // State and registered outputs
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         MODE     <= RUN;
         RUN_EN   <= 1'b1;
         INC_SEC  <= 1'b0;
         INC_MIN  <= 1'b0;
         INC_HOUR <= 1'b0;
         CLR_SEC  <= 1'b0;
         BLINK_N  <= 6'b111111;
         phase    <= 1'b0;
         tcnt     <= '0;
      end else begin
         MODE     <= mode_nxt;
         RUN_EN   <= run_en_nxt;
         INC_SEC  <= inc_sec_nxt;
         INC_MIN  <= inc_min_nxt;
         INC_HOUR <= inc_hour_nxt;
         CLR_SEC  <= clr_sec_nxt;
         BLINK_N  <= blink_nxt;
         phase    <= phase_nxt;
         tcnt     <= tcnt_nxt;
      end
   end

   // Next-state, strobe, timeout and blink logic; timeout outranks every key
   always_comb begin
      mode_nxt     = MODE;
      inc_sec_nxt  = 1'b0;
      inc_min_nxt  = 1'b0;
      inc_hour_nxt = 1'b0;
      clr_sec_nxt  = 1'b0;
      tcnt_nxt     = tcnt;
      phase_nxt    = phase;
      blink_nxt    = 6'b111111;

      key_any = KEY_MODE | KEY_INC | KEY_CLR;
      timeout = (MODE != RUN) && TICK_1HZ && (tcnt == TO_LAST);

      if (timeout) begin
         mode_nxt = RUN;
      end else if (KEY_MODE) begin
         mode_nxt = 2'(MODE + 2'd1);
      end else begin
         case (MODE)
            SET_HOUR: inc_hour_nxt = KEY_INC;
            SET_MIN:  inc_min_nxt  = KEY_INC;
            SET_SEC: begin
               clr_sec_nxt = KEY_CLR;
               inc_sec_nxt = KEY_INC & ~KEY_CLR;
            end
            default: ;
         endcase
      end

      mode_chg = (mode_nxt != MODE);

      if ((MODE == RUN) || mode_chg || key_any) begin
         tcnt_nxt = '0;
      end else if (TICK_1HZ) begin
         tcnt_nxt = TW'(tcnt + TW'(1));
      end

      // Edited digits stay lit while the user is adjusting
      if ((MODE == RUN) || mode_chg || KEY_INC || KEY_CLR) begin
         phase_nxt = 1'b0;
      end else if (TICK_2HZ) begin
         phase_nxt = ~phase;
      end

      case (mode_nxt)
         SET_HOUR: blink_nxt[5:4] = {2{~phase_nxt}};
         SET_MIN:  blink_nxt[3:2] = {2{~phase_nxt}};
         SET_SEC:  blink_nxt[1:0] = {2{~phase_nxt}};
         default: ;
      endcase

      run_en_nxt = (mode_nxt != SET_SEC);
   end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed scenarios plus random key/tick traffic,
// compared every cycle against a behavioural model of the watch UI.
module tb_watch_set_ctrl;

   localparam int TO = 3;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       KEY_MODE, KEY_INC, KEY_CLR, TICK_1HZ, TICK_2HZ;
   logic       RUN_EN, INC_SEC, INC_MIN, INC_HOUR, CLR_SEC;
   logic [1:0] MODE;
   logic [5:0] BLINK_N;

   int n_vec = 0;
   int n_err = 0;

   // Model: mode as 0..3, seconds idle in SET, blink phase, last strobe
   int m_mode  = 0;
   int m_idle  = 0;
   int m_phase = 0;
   int m_strb  = 0;  // bit3 hour, bit2 min, bit1 sec, bit0 clr

   watch_set_ctrl #(.TIMEOUT_S(TO)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC), .KEY_CLR(KEY_CLR),
      .TICK_1HZ(TICK_1HZ), .TICK_2HZ(TICK_2HZ),
      .RUN_EN(RUN_EN), .INC_SEC(INC_SEC), .INC_MIN(INC_MIN),
      .INC_HOUR(INC_HOUR), .CLR_SEC(CLR_SEC),
      .MODE(MODE), .BLINK_N(BLINK_N)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int exp_blink(input int md, input int ph);
      int b = 63;
      if (md != 0 && ph != 0) b = b & ~(3 << (2 * (3 - md)));
      return b;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".mode"},   8'(MODE),    8'(m_mode));
      check({tag, ".run_en"}, 8'(RUN_EN),  8'(m_mode != 3));
      check({tag, ".strobe"}, 8'({INC_HOUR, INC_MIN, INC_SEC, CLR_SEC}), 8'(m_strb));
      check({tag, ".blink"},  8'(BLINK_N), 8'(exp_blink(m_mode, m_phase)));
   endtask

   // One clock: drive inputs, advance model, compare just after the edge
   task automatic apply(input string tag, input bit km, input bit ki, input bit kc,
                        input bit t1, input bit t2);
      int nm;
      KEY_MODE = km; KEY_INC = ki; KEY_CLR = kc; TICK_1HZ = t1; TICK_2HZ = t2;
      @(posedge CLOCK);
      m_strb = 0;
      if (m_mode != 0 && t1 && m_idle + 1 == TO) nm = 0;
      else if (km) nm = (m_mode + 1) % 4;
      else begin
         nm = m_mode;
         if (m_mode == 1 && ki) m_strb = 8;
         if (m_mode == 2 && ki) m_strb = 4;
         if (m_mode == 3) m_strb = kc ? 1 : (ki ? 2 : 0);
      end
      if (nm != m_mode || m_mode == 0 || km || ki || kc) m_idle = 0;
      else if (t1) m_idle++;
      if (nm != m_mode || m_mode == 0 || ki || kc) m_phase = 0;
      else if (t2) m_phase ^= 1;
      m_mode = nm;
      #1;
      check_all(tag);
      KEY_MODE = 0; KEY_INC = 0; KEY_CLR = 0; TICK_1HZ = 0; TICK_2HZ = 0;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) apply(tag, 0, 0, 0, 0, 0);
   endtask

   task automatic goto_mode(input int md);
      for (int i = 0; i < 4 && m_mode != md; i++) apply("nav", 1, 0, 0, 0, 0);
   endtask

   initial begin
      RESET = 1'b0;
      KEY_MODE = 0; KEY_INC = 0; KEY_CLR = 0; TICK_1HZ = 0; TICK_2HZ = 0;
      repeat (3) @(posedge CLOCK);
      #1;
      check_all("reset");
      RESET = 1'b1;

      // 1: mode cycling
      for (int k = 0; k < 4; k++) begin
         apply("t1_mode", 1, 0, 0, 0, 0);
         idle("t1_gap", 5);
      end

      // 2: INC_MIN pulses, then ignored in RUN
      goto_mode(2);
      for (int k = 0; k < 3; k++) begin
         apply("t2_inc", 0, 1, 0, 0, 0);
         idle("t2_gap", 2);
      end
      goto_mode(0);
      for (int k = 0; k < 3; k++) begin
         apply("t2_run", 0, 1, 1, 0, 0);
         idle("t2_rgap", 2);
      end

      // 3: priorities
      goto_mode(3);
      apply("t3_clr_inc", 0, 1, 1, 0, 0);
      idle("t3_gap", 2);
      apply("t3_mode_inc", 1, 1, 0, 0, 0);
      idle("t3_gap2", 2);

      // 4: timeout, with and without a key restarting it
      goto_mode(1);
      for (int k = 0; k < 3; k++) begin
         apply("t4_tick", 0, 0, 0, 1, 0);
         idle("t4_gap", 2);
      end
      check("t4_to_run", 8'(MODE), 8'd0);
      goto_mode(1);
      apply("t4b_tick1", 0, 0, 0, 1, 0);
      apply("t4b_tick2k", 0, 1, 0, 1, 0);
      apply("t4b_tick3", 0, 0, 0, 1, 0);
      apply("t4b_tick4", 0, 0, 0, 1, 0);
      check("t4b_still_set", 8'(MODE), 8'd1);
      apply("t4b_tick5", 0, 0, 0, 1, 0);
      check("t4b_to_run", 8'(MODE), 8'd0);

      // 5: blink in SET_HOUR, then key forces digits lit
      goto_mode(1);
      for (int k = 0; k < 4; k++) begin
         apply("t5_blink", 0, 0, 0, 0, 1);
         idle("t5_gap", 1);
      end
      apply("t5_blink", 0, 0, 0, 0, 1);
      apply("t5_inc", 0, 1, 0, 0, 0);
      check("t5_lit", 8'(BLINK_N), 8'h3f);

      // 6: reset during KEY_INC in SET_SEC cancels the strobe
      goto_mode(3);
      KEY_INC = 1'b1;
      #2 RESET = 1'b0;
      m_mode = 0; m_idle = 0; m_phase = 0; m_strb = 0;
      #1;
      check_all("t6_async");
      @(posedge CLOCK);
      #1;
      check_all("t6_held");
      KEY_INC = 1'b0;
      RESET = 1'b1;
      idle("t6_after", 2);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         apply("rand",
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
